// File: rtl/snn_ctrl_pkg.sv
// Constants shared by the SNN control path: FSM encodings, ctrl/status bit positions,
// and the neuron parameter defaults the scheduler presents out of reset.
package snn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_LEAK   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_STEP   = 3'd4,
        ST_DONE   = 3'd5
    } sched_state_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_START = 1;
    localparam int CTRL_SRST  = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ERR       = 2;
    localparam int STAT_STATE_LSB = 3;
    localparam int STAT_STATE_MSB = 5;
    localparam int STAT_TS_LSB    = 16;
    localparam int STAT_TS_MSB    = 31;

    localparam logic [15:0] DEF_LEAK   = 16'd10;
    localparam logic [15:0] DEF_THRESH = 16'd1000;
    localparam logic [15:0] DEF_REFRAC = 16'd20;

    function automatic logic [31:0] pack_status(input sched_state_e st, input logic err,
                                                input logic [15:0] ts);
        logic [31:0] s;
        s = '0;
        s[STAT_BUSY] = (st != ST_IDLE) && (st != ST_DONE);
        s[STAT_DONE] = (st == ST_DONE);
        s[STAT_ERR]  = err;
        s[STAT_STATE_MSB:STAT_STATE_LSB] = st;
        s[STAT_TS_MSB:STAT_TS_LSB] = ts;
        return s;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit up counter that sticks at all-ones; a clear in the same cycle as an increment wins.
module sat_counter32 #(
    parameter logic [31:0] RESET_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= RESET_VAL;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Timestep sequencer for the LIF array: drain events, sweep leak over all neurons,
// settle, advance the timestep counter; also builds status/spike readback values.
module snn_timestep_scheduler
    import snn_ctrl_pkg::*;
#(
    parameter int NUM_NEURONS   = 256,
    parameter int NID_W         = 8,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic [31:0]      ctrl_reg,
    input  logic [31:0]      config_reg,
    input  logic [15:0]      leak_rate,
    input  logic [15:0]      threshold,
    input  logic [15:0]      refractory_period,
    input  logic             evq_empty,
    input  logic             neuron_busy,
    input  logic             spike_in,
    output logic             leak_valid,
    input  logic             leak_ready,
    output logic [NID_W-1:0] leak_idx,
    output logic [15:0]      p_leak,
    output logic [15:0]      p_thresh,
    output logic [15:0]      p_refrac,
    output logic             neuron_clear,
    output logic             ts_tick,
    output logic             done_irq,
    output logic [31:0]      status_reg,
    output logic [31:0]      spike_count
);

    localparam int              DC_W     = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DC_W-1:0] DC_LAST  = DC_W'(DRAIN_TIMEOUT - 1);
    localparam logic [NID_W-1:0] IDX_LAST = NID_W'(NUM_NEURONS - 1);

    sched_state_e     state_q, state_d;
    logic             start_sync_q, start_sync_d;
    logic             start_prev_q, start_prev_d;
    logic             start_edge_q, start_edge_d;
    logic [15:0]      num_ts_q, num_ts_d;
    logic [15:0]      p_leak_q, p_leak_d;
    logic [15:0]      p_thresh_q, p_thresh_d;
    logic [15:0]      p_refrac_q, p_refrac_d;
    logic [15:0]      ts_cnt_q, ts_cnt_d;
    logic             err_q, err_d;
    logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic             leak_valid_q, leak_valid_d;
    logic [NID_W-1:0] leak_idx_q, leak_idx_d;
    logic             neuron_clear_q, neuron_clear_d;
    logic             ts_tick_q, ts_tick_d;
    logic             done_irq_q, done_irq_d;
    logic [31:0]      status_q, status_d;

    logic        srst, en, start_go, accept;
    logic [15:0] ts_inc;
    logic        unused_bits;

    assign unused_bits = ^{ctrl_reg[31:3], config_reg[31:16]};

    always_comb begin
        srst     = ctrl_reg[CTRL_SRST];
        en       = ctrl_reg[CTRL_EN];
        start_go = start_edge_q && en && !srst && (state_q == ST_IDLE || state_q == ST_DONE);
        accept   = leak_valid_q && leak_ready;
        ts_inc   = ts_cnt_q + 16'd1;

        start_sync_d   = ctrl_reg[CTRL_START];
        start_prev_d   = start_sync_q;
        // An edge arriving under soft reset is dropped rather than replayed afterwards.
        start_edge_d   = start_sync_q && !start_prev_q && !srst;
        neuron_clear_d = srst;

        state_d     = state_q;
        num_ts_d    = num_ts_q;
        p_leak_d    = p_leak_q;
        p_thresh_d  = p_thresh_q;
        p_refrac_d  = p_refrac_q;
        ts_cnt_d    = ts_cnt_q;
        err_d       = err_q;
        drain_cnt_d = drain_cnt_q;
        leak_idx_d  = leak_idx_q;

        if (srst) begin
            state_d     = ST_IDLE;
            ts_cnt_d    = '0;
            err_d       = 1'b0;
            drain_cnt_d = '0;
            leak_idx_d  = '0;
        end else if (start_go) begin
            state_d     = ST_DRAIN;
            num_ts_d    = config_reg[15:0];
            p_leak_d    = leak_rate;
            p_thresh_d  = threshold;
            p_refrac_d  = refractory_period;
            ts_cnt_d    = '0;
            err_d       = 1'b0;
            drain_cnt_d = '0;
            leak_idx_d  = '0;
        end else if (!en && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_DRAIN: begin
                    if (evq_empty && !neuron_busy) begin
                        state_d    = ST_LEAK;
                        leak_idx_d = '0;
                    end else if (drain_cnt_q == DC_LAST) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
                ST_LEAK: begin
                    if (accept) begin
                        if (leak_idx_q == IDX_LAST) begin
                            leak_idx_d = '0;
                            state_d    = ST_SETTLE;
                        end else begin
                            leak_idx_d = leak_idx_q + 1'b1;
                        end
                    end
                end
                ST_SETTLE: if (!neuron_busy) state_d = ST_STEP;
                ST_STEP: begin
                    ts_cnt_d = ts_inc;
                    if (num_ts_q != 16'd0 && ts_inc == num_ts_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        leak_valid_d = (state_d == ST_LEAK);
        ts_tick_d    = (state_d == ST_STEP);
        done_irq_d   = (state_d == ST_DONE) && (state_q != ST_DONE);
        status_d     = pack_status(state_d, err_d, ts_cnt_d);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q        <= ST_IDLE;
            start_sync_q   <= 1'b0;
            start_prev_q   <= 1'b0;
            start_edge_q   <= 1'b0;
            num_ts_q       <= '0;
            p_leak_q       <= DEF_LEAK;
            p_thresh_q     <= DEF_THRESH;
            p_refrac_q     <= DEF_REFRAC;
            ts_cnt_q       <= '0;
            err_q          <= 1'b0;
            drain_cnt_q    <= '0;
            leak_valid_q   <= 1'b0;
            leak_idx_q     <= '0;
            neuron_clear_q <= 1'b0;
            ts_tick_q      <= 1'b0;
            done_irq_q     <= 1'b0;
            status_q       <= '0;
        end else begin
            state_q        <= state_d;
            start_sync_q   <= start_sync_d;
            start_prev_q   <= start_prev_d;
            start_edge_q   <= start_edge_d;
            num_ts_q       <= num_ts_d;
            p_leak_q       <= p_leak_d;
            p_thresh_q     <= p_thresh_d;
            p_refrac_q     <= p_refrac_d;
            ts_cnt_q       <= ts_cnt_d;
            err_q          <= err_d;
            drain_cnt_q    <= drain_cnt_d;
            leak_valid_q   <= leak_valid_d;
            leak_idx_q     <= leak_idx_d;
            neuron_clear_q <= neuron_clear_d;
            ts_tick_q      <= ts_tick_d;
            done_irq_q     <= done_irq_d;
            status_q       <= status_d;
        end
    end

    sat_counter32 u_spike_cnt (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .clr   (srst || start_go),
        .inc   (spike_in && (state_q != ST_IDLE)),
        .count (spike_count)
    );

    assign leak_valid   = leak_valid_q;
    assign leak_idx     = leak_idx_q;
    assign p_leak       = p_leak_q;
    assign p_thresh     = p_thresh_q;
    assign p_refrac     = p_refrac_q;
    assign neuron_clear = neuron_clear_q;
    assign ts_tick      = ts_tick_q;
    assign done_irq     = done_irq_q;
    assign status_reg   = status_q;

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Scoreboard bench for the timestep scheduler with a 4-neuron array and a 16-cycle drain limit.
module tb_snn_timestep_scheduler;
    import snn_ctrl_pkg::*;

    localparam int NN  = 4;
    localparam int NW  = 2;
    localparam int DTO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   ctrl_reg = '0, config_reg = '0;
    logic [15:0]   leak_rate = '0, threshold = '0, refractory_period = '0;
    logic          evq_empty = 1'b1, neuron_busy = 1'b0, spike_in = 1'b0, leak_ready = 1'b1;
    logic          leak_valid, neuron_clear, ts_tick, done_irq;
    logic [NW-1:0] leak_idx;
    logic [15:0]   p_leak, p_thresh, p_refrac;
    logic [31:0]   status_reg, spike_count;
    logic          sc_clr = 1'b0, sc_inc = 1'b0;
    logic [31:0]   sc_cnt;

    int            n_chk = 0, n_pass = 0, cyc = 0, got, seen, n;
    logic [NW-1:0] lk_q[$];
    int            tick_cyc[$];
    logic [31:0]   sc_q[$];
    logic [31:0]   sc_model;
    bit            lk_mon = 1'b0, prev_stall = 1'b0;
    logic [NW-1:0] prev_idx = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snn_timestep_scheduler #(.NUM_NEURONS(NN), .NID_W(NW), .DRAIN_TIMEOUT(DTO)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .ctrl_reg(ctrl_reg), .config_reg(config_reg),
        .leak_rate(leak_rate), .threshold(threshold), .refractory_period(refractory_period),
        .evq_empty(evq_empty), .neuron_busy(neuron_busy), .spike_in(spike_in),
        .leak_valid(leak_valid), .leak_ready(leak_ready), .leak_idx(leak_idx),
        .p_leak(p_leak), .p_thresh(p_thresh), .p_refrac(p_refrac), .neuron_clear(neuron_clear),
        .ts_tick(ts_tick), .done_irq(done_irq), .status_reg(status_reg), .spike_count(spike_count)
    );

    sat_counter32 #(.RESET_VAL(32'hFFFF_FFFE)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(sc_clr), .inc(sc_inc), .count(sc_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Start pulse sampled at the next edge; DRAIN is visible two edges after that.
    task automatic start_run();
        ctrl_reg[CTRL_START] = 1'b1;
        tick();
        ctrl_reg[CTRL_START] = 1'b0;
        tick(2);
    endtask

    task automatic push_sweeps(input int s);
        for (int j = 0; j < s; j++)
            for (int i = 0; i < NN; i++) lk_q.push_back(NW'(i));
    endtask

    task automatic wait_done(input string tag, input int max);
        int ok = 0;
        for (int i = 0; i < max && ok == 0; i++) begin
            if (done_irq) ok = 1;
            else tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int max);
        int ok = 0;
        for (int i = 0; i < max && ok == 0; i++) begin
            if (status_reg[5:3] == st) ok = 1;
            else tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // Leak handshake monitor: each acceptance pops the next expected index.
    always @(negedge clk) begin
        if (rst_n && lk_mon) begin
            if (prev_stall && leak_valid) chk("leak_hold", 32'(leak_idx), 32'(prev_idx));
            if (leak_valid && leak_ready) begin
                if (lk_q.size() > 0) chk("leak_idx", 32'(leak_idx), 32'(lk_q.pop_front()));
                else chk("leak_extra", 32'(lk_q.size()), 32'd1);
            end
        end
        prev_stall = leak_valid && !leak_ready;
        prev_idx   = leak_idx;
        if (ts_tick) tick_cyc.push_back(cyc);
    end

    initial begin
        #12;
        chk("rst_status", status_reg, 32'h0);
        chk("rst_plk", 32'(p_leak), 32'd10);
        chk("rst_pth", 32'(p_thresh), 32'd1000);
        chk("rst_prf", 32'(p_refrac), 32'd20);
        chk("rst_lv", 32'(leak_valid), 32'd0);
        chk("rst_idx", 32'(leak_idx), 32'd0);
        chk("rst_spk", spike_count, 32'd0);
        chk("rst_outs", 32'({neuron_clear, ts_tick, done_irq}), 32'd0);
        chk("rst_sat", sc_cnt, 32'hFFFF_FFFE);
        rst_n = 1'b1;
        tick();

        // Three-timestep run, no backpressure.
        ctrl_reg = 32'h1; config_reg = 32'd3;
        leak_rate = 16'd5; threshold = 16'd77; refractory_period = 16'd9;
        lk_mon = 1'b1; push_sweeps(3); tick_cyc.delete();
        start_run();
        chk("run_drain", 32'(status_reg[5:3]), 32'd1);
        wait_done("run_done", 100);
        chk("run_status", status_reg, 32'h0003_002A);
        chk("run_ticks", 32'(tick_cyc.size()), 32'd3);
        if (tick_cyc.size() == 3) begin
            chk("run_gap1", 32'(tick_cyc[1] - tick_cyc[0]), 32'd7);
            chk("run_gap2", 32'(tick_cyc[2] - tick_cyc[1]), 32'd7);
        end
        chk("run_leak_left", 32'(lk_q.size()), 32'd0);
        chk("run_plk", 32'(p_leak), 32'd5);
        chk("run_pth", 32'(p_thresh), 32'd77);
        chk("run_prf", 32'(p_refrac), 32'd9);
        tick();
        chk("run_irq_pulse", 32'(done_irq), 32'd0);

        // Backpressure: ready toggles every cycle.
        config_reg = 32'd1; push_sweeps(1);
        start_run();
        got = 0;
        for (int i = 0; i < 60 && got == 0; i++) begin
            if (done_irq) got = 1;
            else begin leak_ready = ~leak_ready; tick(); end
        end
        leak_ready = 1'b1;
        chk("bp_done", 32'(got), 32'd1);
        chk("bp_leak_left", 32'(lk_q.size()), 32'd0);
        chk("bp_ts", 32'(status_reg[31:16]), 32'd1);

        // Drain timeout.
        evq_empty = 1'b0; config_reg = 32'd2;
        start_run();
        n = 0;
        for (int i = 0; i < 40 && status_reg[5:3] == 3'd1; i++) begin n++; tick(); end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_err", 32'(status_reg[2]), 32'd1);
        chk("to_state", 32'(status_reg[5:3]), 32'd5);
        chk("to_irq", 32'(done_irq), 32'd1);
        evq_empty = 1'b1; config_reg = 32'd0; lk_mon = 1'b0;
        start_run();
        chk("to_err_clr", 32'(status_reg[2]), 32'd0);

        // Abort in the second sweep at leak_idx 2.
        got = 0; seen = 0;
        for (int i = 0; i < 60 && got == 0; i++) begin
            if (ts_tick) seen = 1;
            if (seen != 0 && leak_valid && leak_idx == NW'(2)) got = 1;
            else tick();
        end
        chk("ab_reach", 32'(got), 32'd1);
        ctrl_reg[CTRL_EN] = 1'b0;
        tick();
        chk("ab_state", 32'(status_reg[5:3]), 32'd0);
        chk("ab_valid", 32'(leak_valid), 32'd0);
        chk("ab_ts", 32'(status_reg[31:16]), 32'd1);

        // Spikes: one counted run, then a spike colliding with the next start.
        ctrl_reg = 32'h1; config_reg = 32'd1; lk_mon = 1'b1; push_sweeps(1);
        start_run();
        tick();
        spike_in = 1'b1; tick(); spike_in = 1'b0;
        chk("spk_one", spike_count, 32'd1);
        wait_done("spk_done1", 40);
        push_sweeps(1);
        ctrl_reg[CTRL_START] = 1'b1; tick();
        ctrl_reg[CTRL_START] = 1'b0; tick();
        spike_in = 1'b1; tick(); spike_in = 1'b0;
        chk("spk_clr_wins", spike_count, 32'd0);
        repeat (4) begin spike_in = 1'b1; tick(); spike_in = 1'b0; tick(); end
        chk("spk_cnt", spike_count, 32'd4);
        wait_state("spk_done2", 3'd5, 40);
        chk("spk_leak_left", 32'(lk_q.size()), 32'd0);
        lk_mon = 1'b0;

        // Soft reset while held in SETTLE, with a start edge that must be ignored.
        config_reg = 32'd0;
        start_run();
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            if (ts_tick) got = 1;
            else tick();
        end
        chk("sr_tick", 32'(got), 32'd1);
        tick();
        spike_in = 1'b1; tick(); spike_in = 1'b0;
        neuron_busy = 1'b1;
        wait_state("sr_settle", 3'd3, 20);
        chk("sr_pre_ts", 32'(status_reg[31:16]), 32'd1);
        chk("sr_pre_spk", spike_count, 32'd1);
        ctrl_reg[CTRL_SRST] = 1'b1; ctrl_reg[CTRL_START] = 1'b1;
        tick();
        chk("sr_status", status_reg, 32'h0);
        chk("sr_nclr", 32'(neuron_clear), 32'd1);
        chk("sr_spk", spike_count, 32'd0);
        tick(3);
        chk("sr_hold", status_reg, 32'h0);
        ctrl_reg[CTRL_SRST] = 1'b0;
        tick();
        chk("sr_nclr_off", 32'(neuron_clear), 32'd0);
        tick(4);
        chk("sr_start_ignored", status_reg, 32'h0);
        ctrl_reg[CTRL_START] = 1'b0; neuron_busy = 1'b0;

        // Saturating counter from a near-full preload.
        sc_model = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            sc_inc = 1'b1;
            sc_clr = (i == 3);
            sc_model = sc_clr ? 32'h0 : ((sc_model != 32'hFFFF_FFFF) ? sc_model + 32'd1 : sc_model);
            sc_q.push_back(sc_model);
            tick();
            chk("sat_cnt", sc_cnt, sc_q.pop_front());
        end
        sc_inc = 1'b0; sc_clr = 1'b0;

        // Asynchronous reset mid-run, observed before any further clock edge.
        start_run();
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_status", status_reg, 32'h0);
        chk("arst_lv", 32'(leak_valid), 32'd0);
        chk("arst_plk", 32'(p_leak), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/snn_timestep_scheduler.md
# snn_timestep_scheduler

Sequences the LIF neuron array one timestep at a time under control of the AXI-Lite register block's `ctrl_reg`/`config_reg`. Each timestep it waits for the spike event queue to drain, sweeps a leak update across every neuron, waits for the array to settle, and then advances the timestep counter. It also produces the `status_reg` and `spike_count` values that the register block returns on reads. It sits between the register block, the event queue and the neuron array, in the S_AXI_ACLK domain.

## Interface
- `NUM_NEURONS`, default 256: neurons swept per timestep; must be at least 2.
- `NID_W`, default 8: neuron index width, equal to clog2(NUM_NEURONS).
- `DRAIN_TIMEOUT`, default 4096: maximum number of cycles spent in DRAIN before an error is raised.
- `S_AXI_ACLK` in 1: the single clock.
- `S_AXI_ARESETN` in 1: asynchronous, active-low reset.
- `ctrl_reg` in 32:
  - [0] enable.
  - [1] start; rising edge triggers a run.
  - [2] soft_reset; level-sensitive.
- `config_reg` in 32: [15:0] num_timesteps; 0 means run continuously.
- `leak_rate`, `threshold`, `refractory_period` in 16 each: neuron parameters.
- `evq_empty` in 1: the event queue is empty.
- `neuron_busy` in 1: the neuron array has updates in flight.
- `spike_in` in 1: one-cycle pulse per output spike.
- `leak_valid` out 1, `leak_ready` in 1, `leak_idx` out NID_W: leak-sweep handshake.
- `p_leak`, `p_thresh`, `p_refrac` out 16 each: parameters latched at start.
- `neuron_clear` out 1: clears neuron state.
- `ts_tick` out 1: one-cycle pulse at the end of each timestep.
- `done_irq` out 1: one-cycle pulse on entering DONE.
- `status_reg` out 32, `spike_count` out 32: readback values for the register block.

## Operation
- FSM states and encodings: IDLE=0, DRAIN=1, LEAK=2, SETTLE=3, STEP=4, DONE=5.
- Start condition: registered rising edge of ctrl_reg[1], with enable=1, in IDLE or DONE.
  - Latches num_timesteps, p_leak, p_thresh and p_refrac.
  - Clears ts_cnt, spike_count and err.
  - Moves the FSM to DRAIN.
- DRAIN:
  - Waits for evq_empty && !neuron_busy, then goes to LEAK with leak_idx=0.
  - drain_cnt counts the cycles spent in DRAIN.
  - If drain_cnt reaches DRAIN_TIMEOUT-1: set err and go to DONE.
- LEAK:
  - leak_valid=1 throughout.
  - On each leak_valid && leak_ready, leak_idx increments.
  - Acceptance at idx=NUM_NEURONS-1 goes to SETTLE; leak_idx returns to 0.
  - leak_idx holds while leak_ready=0.
- SETTLE: waits for !neuron_busy, then goes to STEP.
- STEP:
  - One cycle; ts_tick=1; ts_cnt increments.
  - If num_timesteps≠0 and the new ts_cnt equals num_timesteps: go to DONE; otherwise go to DRAIN.
  - ts_cnt wraps modulo 2^16 in continuous mode.
- DONE: done_irq=1 on the entry cycle only; the FSM stays here until the next start.
- Abort: enable=0 in any non-IDLE state moves the FSM to IDLE on the next edge.
  - leak_valid falls on that same edge.
  - Counters hold their values.
- soft_reset=1 takes priority over everything:
  - FSM forced to IDLE; ts_cnt, spike_count and err are cleared.
  - neuron_clear is high while soft_reset is high, registered (one cycle of lag).
  - A start edge seen while soft_reset=1 is ignored.
- spike_count:
  - Increments on spike_in in any state other than IDLE.
  - Saturates at 0xFFFF_FFFF.
  - When a clear (start or soft_reset) coincides with spike_in, the clear wins and the count is 0.
- status_reg layout:
  - [0] busy, meaning state ∉ {IDLE, DONE}.
  - [1] done, meaning state=DONE.
  - [2] err, sticky.
  - [5:3] state encoding.
  - [15:6] zero.
  - [31:16] ts_cnt.

## Timing
- All outputs are registered. Reset values:
  - State IDLE; leak_valid=0; leak_idx=0.
  - p_leak=10, p_thresh=1000, p_refrac=20.
  - ts_cnt=0, spike_count=0, err=0.
  - neuron_clear=0, ts_tick=0, done_irq=0, status_reg=0.
- Start latency: start edge sampled at edge N; the edge detector registers it at N+1; state=DRAIN after edge N+2.
- With the queue already empty and leak_ready tied high, a timestep takes NUM_NEURONS+3 cycles: 1 DRAIN, NUM_NEURONS LEAK, 1 SETTLE, 1 STEP.
- leak_valid follows the AXI rule: once asserted it does not fall until accepted, except on abort or soft_reset.
- Reset assertion mid-run takes effect immediately, asynchronously; outputs go to their reset values without waiting for a clock edge.

## Structure
- A shared package `snn_ctrl_pkg` holds:
  - State encodings.
  - ctrl_reg bit positions (CTRL_EN=0, CTRL_START=1, CTRL_SRST=2).
  - status_reg field positions.
  - Default parameter values.
- The register block imports the same constants.
- One sub-module, `sat_counter32`: a 32-bit saturating counter with clear priority, used for spike_count.

## Test plan
- Run: NUM_NEURONS=4, num_timesteps=3, leak_ready=1, evq_empty=1.
  - Expect 3 ts_tick pulses 7 cycles apart.
  - Expect leak_idx sequence 0,1,2,3 in each sweep.
  - Expect a done_irq pulse and status_reg=0x0003_002A (done, state 5, ts_cnt 3).
- Backpressure: leak_ready toggles 1/0 → leak_idx holds while ready=0; still exactly 4 acceptances per sweep.
- Timeout: DRAIN_TIMEOUT=16, evq_empty=0.
  - Expect DONE after 16 DRAIN cycles with status_reg[2]=1.
  - The next start clears err.
- Abort: clear enable mid-LEAK at leak_idx=2 → next cycle state=IDLE, leak_valid=0, ts_cnt unchanged.
- Spikes: 5 spike_in pulses, with one coinciding with a start edge.
  - spike_count counts only pulses after the clear.
  - Preloaded at 0xFFFF_FFFE, three pulses → 0xFFFF_FFFF.
- Soft reset during SETTLE → next edge state=IDLE, neuron_clear=1, counters 0; a start edge while soft_reset is high is ignored.
